// File: rtl/vga_pkg.sv
// Shared definitions for the OV7670 capture path: frame geometry defaults,
// capture FSM states and RGB565 colour-bar palette.
package vga_pkg;

  localparam int H_RES_DEF = 320;
  localparam int V_RES_DEF = 240;

  typedef enum logic [1:0] {
    S_IDLE,
    S_VSYNC,
    S_ACTIVE
  } cap_state_t;

  localparam logic [15:0] C_WHITE   = 16'hFFFF;
  localparam logic [15:0] C_YELLOW  = 16'hFFE0;
  localparam logic [15:0] C_CYAN    = 16'h07FF;
  localparam logic [15:0] C_GREEN   = 16'h07E0;
  localparam logic [15:0] C_MAGENTA = 16'hF81F;
  localparam logic [15:0] C_RED     = 16'hF800;
  localparam logic [15:0] C_BLUE    = 16'h001F;
  localparam logic [15:0] C_BLACK   = 16'h0000;

  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    logic [15:0] c;
    unique case (idx)
      3'd0: c = C_WHITE;
      3'd1: c = C_YELLOW;
      3'd2: c = C_CYAN;
      3'd3: c = C_GREEN;
      3'd4: c = C_MAGENTA;
      3'd5: c = C_RED;
      3'd6: c = C_BLUE;
      3'd7: c = C_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ov7670_byte_pack.sv
// Byte-phase tracker that pairs two camera bytes into one RGB565 word.
// The first byte of a pair becomes the high half of the pixel.
module ov7670_byte_pack
  import vga_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        vld,
  input  logic [7:0]  byte_in,
  output logic        phase,
  output logic        pix_done,
  output logic [15:0] pixel
);

  logic       phase_q, phase_d;
  logic [7:0] hi_q, hi_d;

  always_comb begin
    phase_d = phase_q;
    hi_d    = hi_q;
    if (clr) begin
      phase_d = 1'b0;
    end else if (vld) begin
      phase_d = ~phase_q;
      if (!phase_q) hi_d = byte_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= 1'b0;
      hi_q    <= '0;
    end else begin
      phase_q <= phase_d;
      hi_q    <= hi_d;
    end
  end

  assign phase    = phase_q;
  assign pix_done = vld & phase_q & ~clr;
  assign pixel    = {hi_q, byte_in};

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 frame capture into an RGB565 frame buffer write port.
// Define OV7670_TEST_PATTERN_EN to replace camera bytes with colour bars.
module ov7670_capture
  import vga_pkg::*;
#(
  parameter int H_RES  = H_RES_DEF,
  parameter int V_RES  = V_RES_DEF,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        data,
  output logic              we,
  output logic [ADDR_W-1:0] wAddr,
  output logic [15:0]       wData,
  output logic              frame_done,
  output logic              overflow
);

  localparam int COL_W  = $clog2(H_RES + 1);
  localparam int LINE_W = $clog2(V_RES + 1);
  localparam logic [COL_W-1:0]  COL_MAX  = COL_W'(H_RES);
  localparam logic [LINE_W-1:0] LINE_MAX = LINE_W'(V_RES);
  localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(H_RES);

  cap_state_t        state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              fdone_q, fdone_d;
  logic              ovf_q, ovf_d;
  logic              href_q, href_d;

  logic        clr, vld, phase, pix_done;
  logic [7:0]  byte_in;
  logic [15:0] pixel;

`ifdef OV7670_TEST_PATTERN_EN
  logic [2:0]  bar_idx;
  logic [15:0] bar_rgb;
  always_comb begin
    bar_idx = 3'((32'(col_q) * 32'd8) / 32'(H_RES));
    bar_rgb = bar_color(bar_idx);
    byte_in = phase ? bar_rgb[7:0] : bar_rgb[15:8];
  end
`else
  assign byte_in = data;
`endif

  ov7670_byte_pack u_pack (
    .clk     (clk),
    .reset   (reset),
    .clr     (clr),
    .vld     (vld),
    .byte_in (byte_in),
    .phase   (phase),
    .pix_done(pix_done),
    .pixel   (pixel)
  );

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    line_d  = line_q;
    base_d  = base_q;
    addr_d  = addr_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    fdone_d = 1'b0;
    ovf_d   = ovf_q;
    href_d  = 1'b0;
    clr     = 1'b1;
    vld     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (vsync) state_d = S_VSYNC;
      end
      S_VSYNC: begin
        if (!vsync) begin
          state_d = S_ACTIVE;
          col_d   = '0;
          line_d  = '0;
          base_d  = '0;
          addr_d  = '0;
        end
      end
      S_ACTIVE: begin
        if (vsync) begin
          // frame end wins over any byte in flight
          state_d = S_VSYNC;
          fdone_d = 1'b1;
        end else begin
          href_d = href;
          vld    = href;
          clr    = href_q & ~href;
          if (clr) begin
            col_d = '0;
            if (line_q < LINE_MAX) begin
              line_d = line_q + LINE_W'(1);
              base_d = base_q + STEP;
              addr_d = base_q + STEP;
            end
          end else if (pix_done) begin
            if (col_q < COL_MAX && line_q < LINE_MAX) begin
              we_d    = 1'b1;
              waddr_d = addr_q;
              wdata_d = pixel;
              addr_d  = addr_q + ADDR_W'(1);
              col_d   = col_q + COL_W'(1);
            end else begin
              ovf_d = 1'b1;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      line_q  <= '0;
      base_q  <= '0;
      addr_q  <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      fdone_q <= 1'b0;
      ovf_q   <= 1'b0;
      href_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      line_q  <= line_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      fdone_q <= fdone_d;
      ovf_q   <= ovf_d;
      href_q  <= href_d;
    end
  end

  assign we         = we_q;
  assign wAddr      = waddr_q;
  assign wData      = wdata_q;
  assign frame_done = fdone_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_ov7670_capture.sv
// Directed bench for ov7670_capture: a full-size instance and a
// small 16x4 instance for whole-frame and line-overflow cases.
module tb_ov7670_capture;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        vsync = 1'b0;
  logic        href = 1'b0;
  logic [7:0]  data = 8'h00;

  logic        we, fd, ovf;
  logic [16:0] waddr;
  logic [15:0] wdata;
  logic        s_we, s_fd, s_ovf;
  logic [5:0]  s_waddr;
  logic [15:0] s_wdata;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int drv_cyc = 0;
  logic [15:0] exp_data = 16'h0000;
  logic        mon_clr = 1'b1;

  int m_cnt, m_first, m_last, m_jump, m_bad, m_fd, m_first_cyc;
  logic [15:0] p0, p40, p319;
  int s_cnt, s_last, s_bad, s_fdc;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  ov7670_capture dut_main (
    .clk       (clk),
    .reset     (reset),
    .vsync     (vsync),
    .href      (href),
    .data      (data),
    .we        (we),
    .wAddr     (waddr),
    .wData     (wdata),
    .frame_done(fd),
    .overflow  (ovf)
  );

  ov7670_capture #(.H_RES(16), .V_RES(4), .ADDR_W(6)) dut_small (
    .clk       (clk),
    .reset     (reset),
    .vsync     (vsync),
    .href      (href),
    .data      (data),
    .we        (s_we),
    .wAddr     (s_waddr),
    .wData     (s_wdata),
    .frame_done(s_fd),
    .overflow  (s_ovf)
  );

  always @(negedge clk) begin
    if (mon_clr) begin
      m_cnt <= 0; m_first <= 0; m_last <= 0; m_jump <= 0;
      m_bad <= 0; m_fd <= 0; m_first_cyc <= 0;
      s_cnt <= 0; s_last <= 0; s_bad <= 0; s_fdc <= 0;
    end else begin
      if (fd) m_fd <= m_fd + 1;
      if (we) begin
        if (m_cnt == 0) begin
          m_first     <= int'(waddr);
          m_first_cyc <= cyc;
        end else if (int'(waddr) != m_last + 1) begin
          m_jump <= m_jump + 1;
        end
        if (wdata != exp_data) m_bad <= m_bad + 1;
        if (waddr == 17'd0)   p0   <= wdata;
        if (waddr == 17'd40)  p40  <= wdata;
        if (waddr == 17'd319) p319 <= wdata;
        m_last <= int'(waddr);
        m_cnt  <= m_cnt + 1;
      end
      if (s_fd) s_fdc <= s_fdc + 1;
      if (s_we) begin
        if (s_wdata != exp_data) s_bad <= s_bad + 1;
        s_last <= int'(s_waddr);
        s_cnt  <= s_cnt + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; vsync = 1'b0; href = 1'b0; data = 8'h00;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic mon_clear();
    mon_clr = 1'b1;
    tick();
    mon_clr = 1'b0;
  endtask

  task automatic frame_start();
    vsync = 1'b1;
    repeat (3) tick();
    vsync = 1'b0;
    repeat (2) tick();
  endtask

  task automatic send_bytes(input int n, input logic [7:0] hi,
                            input logic [7:0] lo);
    for (int i = 0; i < n; i++) begin
      href = 1'b1;
      data = i[0] ? lo : hi;
      if (i == 1) drv_cyc = cyc;
      tick();
    end
  endtask

  task automatic send_line(input int n, input logic [7:0] hi,
                           input logic [7:0] lo);
    send_bytes(n, hi, lo);
    href = 1'b0;
    data = 8'h00;
    repeat (4) tick();
  endtask

  initial begin
    do_reset();
    check("rst_we", 32'(we), 32'd0);
    check("rst_waddr", 32'(waddr), 32'd0);
    check("rst_wdata", 32'(wdata), 32'd0);
    check("rst_fd", 32'(fd), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);

`ifdef OV7670_TEST_PATTERN_EN
    mon_clear();
    frame_start();
    send_line(640, 8'h12, 8'h34);
    check("pat_cnt", 32'(m_cnt), 32'd320);
    check("pat_last", 32'(m_last), 32'd319);
    check("pat_col0", 32'(p0), 32'h0000_FFFF);
    check("pat_col40", 32'(p40), 32'h0000_FFE0);
    check("pat_col319", 32'(p319), 32'h0000_0000);
`else
    // one full line of 0x12,0x34
    exp_data = 16'h1234;
    mon_clear();
    frame_start();
    send_line(640, 8'h12, 8'h34);
    check("l1_cnt", 32'(m_cnt), 32'd320);
    check("l1_first", 32'(m_first), 32'd0);
    check("l1_last", 32'(m_last), 32'd319);
    check("l1_jump", 32'(m_jump), 32'd0);
    check("l1_data", 32'(m_bad), 32'd0);
    check("l1_lat", 32'(m_first_cyc - drv_cyc), 32'd1);
    check("l1_ovf", 32'(ovf), 32'd0);
    do_reset();
    check("rst2_wdata", 32'(wdata), 32'd0);
    check("rst2_waddr", 32'(waddr), 32'd0);

    // 642-byte line overflows, next line starts at 320
    mon_clear();
    frame_start();
    send_line(642, 8'h12, 8'h34);
    check("ov_cnt", 32'(m_cnt), 32'd320);
    check("ov_flag", 32'(ovf), 32'd1);
    mon_clear();
    send_line(640, 8'h12, 8'h34);
    check("ov_next_first", 32'(m_first), 32'd320);
    check("ov_next_cnt", 32'(m_cnt), 32'd320);
    check("ov_sticky", 32'(ovf), 32'd1);
    do_reset();
    check("ov_rst", 32'(ovf), 32'd0);

    // odd-length line drops trailing byte
    mon_clear();
    frame_start();
    send_line(5, 8'h12, 8'h34);
    check("odd_cnt", 32'(m_cnt), 32'd2);
    check("odd_last", 32'(m_last), 32'd1);
    mon_clear();
    send_line(4, 8'h12, 8'h34);
    check("odd_next_first", 32'(m_first), 32'd320);
    check("odd_next_cnt", 32'(m_cnt), 32'd2);

    // mid-frame start, then reset at pixel 100
    do_reset();
    mon_clear();
    send_line(20, 8'h12, 8'h34);
    send_line(20, 8'h12, 8'h34);
    check("mid_nowr", 32'(m_cnt), 32'd0);
    frame_start();
    send_bytes(200, 8'h12, 8'h34);
    reset = 1'b1;
    data = 8'h12;
    tick();
    check("rstmid_we", 32'(we), 32'd0);
    check("rstmid_st", 32'(dut_main.state_q), 32'(vga_pkg::S_IDLE));
    check("rstmid_cnt", 32'(m_cnt), 32'd100);
    reset = 1'b0;
    mon_clear();
    send_line(40, 8'h12, 8'h34);
    check("rstmid_nowr", 32'(m_cnt), 32'd0);

    // phase-1 byte coincident with vsync rising is not written
    do_reset();
    mon_clear();
    frame_start();
    send_bytes(3, 8'h12, 8'h34);
    vsync = 1'b1;
    data = 8'h34;
    tick();
    href = 1'b0;
    repeat (4) tick();
    check("vs_cnt", 32'(m_cnt), 32'd1);
    check("vs_fd", 32'(m_fd), 32'd1);

    // small instance: full 16x4 frame
    exp_data = 16'hABCD;
    do_reset();
    mon_clear();
    frame_start();
    repeat (4) send_line(32, 8'hAB, 8'hCD);
    vsync = 1'b1;
    repeat (4) tick();
    check("fr_cnt", 32'(s_cnt), 32'd64);
    check("fr_last", 32'(s_last), 32'd63);
    check("fr_data", 32'(s_bad), 32'd0);
    check("fr_fd", 32'(s_fdc), 32'd1);
    check("fr_ovf", 32'(s_ovf), 32'd0);

    // small instance: extra line beyond V_RES is dropped
    do_reset();
    mon_clear();
    frame_start();
    repeat (5) send_line(32, 8'hAB, 8'hCD);
    vsync = 1'b1;
    repeat (4) tick();
    check("vr_cnt", 32'(s_cnt), 32'd64);
    check("vr_last", 32'(s_last), 32'd63);
    check("vr_ovf", 32'(s_ovf), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
